// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// - sb_entry_t : one tracked pipeline stage {valid, addr, is_load}
// - CTL_*      : control-hazard channel indices
// - sel_width  : width of a per-port bypass stage select
package hazard_pkg;

    // Entries carry a fixed-width address; designs with narrower ADDR_W zero-extend.
    localparam int unsigned SB_ADDR_W_MAX = 16;

    localparam int unsigned CTL_CALL   = 0;
    localparam int unsigned CTL_RET    = 1;
    localparam int unsigned CTL_BRANCH = 2;

    typedef struct packed {
        logic                     valid;
        logic [SB_ADDR_W_MAX-1:0] addr;
        logic                     is_load;
    } sb_entry_t;

    // Stage select encodes 0 (register file) up to DEPTH.
    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_port_match.sv
// Youngest-match priority encoder for a single decode read port.
// Ports:
//   entries_i : scoreboard, index k holds stage k+1
//   rd_en_i   : port read enable
//   rd_addr_i : port read address
//   hazard_o  : this port must stall
//   sel_o     : bypass stage select, 0 = register file
module hazard_port_match
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned FWD_EN     = 0,
    parameter int unsigned ALU_READY  = 2,
    parameter int unsigned LOAD_READY = 3,
    parameter int unsigned ZERO_HARD  = 0
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic                  hazard_o,
    output logic [SEL_W-1:0]      sel_o
);

    logic [SB_ADDR_W_MAX-1:0] rd_ext;
    logic                     blocked;
    logic                     hit;
    int                       hit_stage;
    logic                     hit_load;

    assign blocked = (ZERO_HARD != 0) && (rd_addr_i == '0);

    always_comb begin
        rd_ext                = '0;
        rd_ext[ADDR_W-1:0]    = rd_addr_i;
    end

    always_comb begin
        hit       = 1'b0;
        hit_stage = 0;
        hit_load  = 1'b0;
        // Scan oldest to youngest so the youngest match overwrites older ones.
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (rd_en_i && !blocked && entries_i[k].valid && (entries_i[k].addr == rd_ext)) begin
                hit       = 1'b1;
                hit_stage = k + 1;
                hit_load  = entries_i[k].is_load;
            end
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        sel_o    = '0;
        if (hit) begin
            if (FWD_EN == 0) begin
                hazard_o = 1'b1;
            end else if (hit_stage >= (hit_load ? int'(LOAD_READY) : int'(ALU_READY))) begin
                sel_o = SEL_W'(hit_stage);
            end else begin
                hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage data/control hazard scoreboard with optional forwarding.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   freeze_i            : global hold, scoreboard does not shift
//   flush_i             : kill decode instruction, bubble enters stage 1
//   wr_en_i/addr/is_load: decode instruction destination info
//   rd_en_i, rd_addr_i  : per-port read requests (packed addresses)
//   ctl_set_i/ctl_clr_i : per-channel control-hazard flag set/clear
//   data_hazard_o       : stall decode this cycle
//   control_hazard_o    : OR of control flags
//   fwd_sel_o           : per-port bypass stage select, 0 = register file
//   stall_cnt_o         : saturating count of hazard cycles
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned NUM_CTL    = 3,
    parameter int unsigned FWD_EN     = 0,
    parameter int unsigned ALU_READY  = 2,
    parameter int unsigned LOAD_READY = 3,
    parameter int unsigned ZERO_HARD  = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 freeze_i,
    input  logic                                 flush_i,
    input  logic                                 wr_en_i,
    input  logic [ADDR_W-1:0]                    wr_addr_i,
    input  logic                                 wr_is_load_i,
    input  logic [NUM_RD-1:0]                    rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]             rd_addr_i,
    input  logic [NUM_CTL-1:0]                   ctl_set_i,
    input  logic [NUM_CTL-1:0]                   ctl_clr_i,
    output logic                                 data_hazard_o,
    output logic                                 control_hazard_o,
    output logic [NUM_RD*sel_width(DEPTH)-1:0]   fwd_sel_o,
    output logic [15:0]                          stall_cnt_o
);

    localparam int unsigned SEL_W = sel_width(DEPTH);

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    sb_entry_t             new_entry;
    logic [NUM_CTL-1:0]    ctl_q, ctl_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;
    logic [NUM_RD-1:0]     port_hazard;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        hazard_port_match #(
            .ADDR_W     (ADDR_W),
            .DEPTH      (DEPTH),
            .SEL_W      (SEL_W),
            .FWD_EN     (FWD_EN),
            .ALU_READY  (ALU_READY),
            .LOAD_READY (LOAD_READY),
            .ZERO_HARD  (ZERO_HARD)
        ) u_match (
            .entries_i (sb_q),
            .rd_en_i   (rd_en_i[g]),
            .rd_addr_i (rd_addr_i[g*ADDR_W +: ADDR_W]),
            .hazard_o  (port_hazard[g]),
            .sel_o     (fwd_sel_o[g*SEL_W +: SEL_W])
        );
    end

    assign data_hazard_o    = |port_hazard;
    assign control_hazard_o = |ctl_q;
    assign stall_cnt_o      = stall_cnt_q;

    // A stalled, flushed or r0-targeting decode instruction enters as a bubble.
    always_comb begin
        new_entry                  = '0;
        new_entry.addr[ADDR_W-1:0] = wr_addr_i;
        new_entry.is_load          = wr_is_load_i;
        new_entry.valid            = wr_en_i & ~data_hazard_o & ~flush_i &
                                     ~((ZERO_HARD != 0) && (wr_addr_i == '0));
    end

    always_comb begin
        sb_d = sb_q;
        if (!freeze_i) begin
            sb_d = {sb_q[DEPTH-2:0], new_entry};
        end
    end

    // Clear wins over set; flags ignore freeze.
    assign ctl_d = (ctl_q | ctl_set_i) & ~ctl_clr_i;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((data_hazard_o || control_hazard_o) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_q        <= '0;
            ctl_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            ctl_q       <= ctl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: dut0 = defaults (stall-only), dut1 = forwarding,
// dut2 = forwarding with hardwired r0. All share the same stimulus and are
// reset between sections; each section checks only the instance it targets.
module tb_hazard_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        freeze_i, flush_i, wr_en_i, wr_is_load_i;
    logic [4:0]  wr_addr_i;
    logic [1:0]  rd_en_i;
    logic [9:0]  rd_addr_i;
    logic [2:0]  ctl_set_i, ctl_clr_i;

    logic        dh0, ch0, dh1, ch1, dh2, ch2;
    logic [5:0]  sel0, sel1, sel2;
    logic [15:0] cnt0, cnt1, cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    hazard_scoreboard u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i), .flush_i(flush_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_is_load_i(wr_is_load_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .ctl_set_i(ctl_set_i), .ctl_clr_i(ctl_clr_i),
        .data_hazard_o(dh0), .control_hazard_o(ch0), .fwd_sel_o(sel0), .stall_cnt_o(cnt0)
    );

    hazard_scoreboard #(.FWD_EN(1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i), .flush_i(flush_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_is_load_i(wr_is_load_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .ctl_set_i(ctl_set_i), .ctl_clr_i(ctl_clr_i),
        .data_hazard_o(dh1), .control_hazard_o(ch1), .fwd_sel_o(sel1), .stall_cnt_o(cnt1)
    );

    hazard_scoreboard #(.FWD_EN(1), .ZERO_HARD(1)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i), .flush_i(flush_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_is_load_i(wr_is_load_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .ctl_set_i(ctl_set_i), .ctl_clr_i(ctl_clr_i),
        .data_hazard_o(dh2), .control_hazard_o(ch2), .fwd_sel_o(sel2), .stall_cnt_o(cnt2)
    );

    typedef struct packed {
        logic       frz;
        logic       fl;
        logic       we;
        logic [4:0] wa;
        logic       wl;
        logic [1:0] re;
        logic [4:0] a0;
        logic [4:0] a1;
        logic [2:0] cs;
        logic [2:0] cc;
        logic       dh;
        logic       ch;
        logic [2:0] s0;
        logic [2:0] s1;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic frz, input logic fl, input logic we,
                                input logic [4:0] wa, input logic wl, input logic [1:0] re,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [2:0] cs, input logic [2:0] cc,
                                input logic dh, input logic ch,
                                input logic [2:0] s0, input logic [2:0] s1);
        vec_t v;
        v.frz = frz; v.fl = fl; v.we = we; v.wa = wa; v.wl = wl; v.re = re;
        v.a0 = a0; v.a1 = a1; v.cs = cs; v.cc = cc;
        v.dh = dh; v.ch = ch; v.s0 = s0; v.s1 = s1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        freeze_i = 0; flush_i = 0; wr_en_i = 0; wr_addr_i = 0; wr_is_load_i = 0;
        rd_en_i = 0; rd_addr_i = 0; ctl_set_i = 0; ctl_clr_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        tick();
        rst_i = 0;
        #1;
    endtask

    initial begin
        // Forwarding-mode table: row inputs applied, outputs checked, then one clock.
        //             frz fl we wa wl re     a0 a1 cs      cc      dh ch s0 s1
        tbl[0]  = mk(0, 0, 1, 7, 0, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 2'b01, 7, 0, 3'b000, 3'b000, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 2'b01, 7, 0, 3'b000, 3'b000, 0, 0, 2, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 2'b01, 7, 0, 3'b000, 3'b000, 0, 0, 3, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 2'b01, 7, 0, 3'b000, 3'b000, 0, 0, 4, 0);
        tbl[5]  = mk(0, 0, 1, 7, 1, 2'b01, 7, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 2'b01, 7, 0, 3'b000, 3'b000, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 2'b01, 7, 0, 3'b000, 3'b000, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 2'b01, 7, 0, 3'b000, 3'b000, 0, 0, 3, 0);
        tbl[9]  = mk(0, 0, 1, 3, 0, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 3, 1, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        // r3 load at stage 1 shadows the ready r3 ALU result at stage 3.
        tbl[12] = mk(0, 0, 0, 0, 0, 2'b01, 3, 3, 3'b000, 3'b000, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 2'b10, 3, 3, 3'b000, 3'b000, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 2'b11, 9, 3, 3'b000, 3'b000, 0, 0, 0, 3);
        tbl[15] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b100, 3'b000, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b100, 3'b100, 0, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b011, 3'b000, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b001, 0, 1, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b010, 0, 1, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);

        idle_inputs();
        rst_i = 1;
        #2;
        chk("reset dh", {31'd0, dh0}, 0);
        chk("reset ch", {31'd0, ch0}, 0);
        chk("reset sel", {26'd0, sel1}, 0);
        chk("reset cnt", {16'd0, cnt0}, 0);
        do_reset();

        // Table on forwarding instance.
        for (int i = 0; i < NV; i++) begin
            freeze_i = tbl[i].frz; flush_i = tbl[i].fl; wr_en_i = tbl[i].we;
            wr_addr_i = tbl[i].wa; wr_is_load_i = tbl[i].wl; rd_en_i = tbl[i].re;
            rd_addr_i = {tbl[i].a1, tbl[i].a0}; ctl_set_i = tbl[i].cs; ctl_clr_i = tbl[i].cc;
            #1;
            chk($sformatf("row%0d dh", i), {31'd0, dh1}, {31'd0, tbl[i].dh});
            chk($sformatf("row%0d ch", i), {31'd0, ch1}, {31'd0, tbl[i].ch});
            chk($sformatf("row%0d sel0", i), {29'd0, sel1[2:0]}, {29'd0, tbl[i].s0});
            chk($sformatf("row%0d sel1", i), {29'd0, sel1[5:3]}, {29'd0, tbl[i].s1});
            tick();
        end
        idle_inputs();
        #1;
        chk("table stall_cnt", {16'd0, cnt1}, 8);

        // Stall-only mode: RAW on r5 stalls for all four tracked stages.
        do_reset();
        wr_en_i = 1; wr_addr_i = 5;
        #1;
        chk("raw pre dh", {31'd0, dh0}, 0);
        tick();
        wr_en_i = 0; wr_addr_i = 0; rd_en_i = 2'b01; rd_addr_i = {5'd0, 5'd5};
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("raw stall c%0d", c), {31'd0, dh0}, 1);
            chk($sformatf("raw sel c%0d", c), {26'd0, sel0}, 0);
            tick();
        end
        #1;
        chk("raw release dh", {31'd0, dh0}, 0);
        chk("raw stall_cnt", {16'd0, cnt0}, 4);

        // Freeze holds the r9 ALU entry at stage 1; flush is ignored while frozen.
        do_reset();
        wr_en_i = 1; wr_addr_i = 9;
        tick();
        wr_en_i = 0; wr_addr_i = 0; freeze_i = 1; flush_i = 1;
        rd_en_i = 2'b01; rd_addr_i = {5'd0, 5'd9};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("freeze dh c%0d", c), {31'd0, dh1}, 1);
            chk($sformatf("freeze sel c%0d", c), {29'd0, sel1[2:0]}, 0);
            tick();
        end
        freeze_i = 0; flush_i = 0;
        #1;
        chk("unfreeze dh", {31'd0, dh1}, 1);
        tick();
        #1;
        chk("unfreeze fwd", {29'd0, sel1[2:0]}, 2);
        chk("unfreeze dh2", {31'd0, dh1}, 0);

        // Flush turns the decode write into a bubble.
        do_reset();
        wr_en_i = 1; wr_addr_i = 6; flush_i = 1;
        tick();
        wr_en_i = 0; flush_i = 0; rd_en_i = 2'b01; rd_addr_i = {5'd0, 5'd6};
        #1;
        chk("flush dh", {31'd0, dh1}, 0);
        chk("flush sel", {29'd0, sel1[2:0]}, 0);

        // r0: hardwired instance ignores it, the other forwarding instance does not.
        do_reset();
        wr_en_i = 1; wr_addr_i = 0;
        tick();
        wr_en_i = 0; rd_en_i = 2'b01; rd_addr_i = 10'd0;
        #1;
        chk("zero hard dh", {31'd0, dh2}, 0);
        chk("zero hard sel", {26'd0, sel2}, 0);
        chk("zero soft dh", {31'd0, dh1}, 1);
        tick();
        #1;
        chk("zero hard dh later", {31'd0, dh2}, 0);
        chk("zero soft sel", {29'd0, sel1[2:0]}, 2);

        // Asynchronous reset mid-cycle with a pending hazard and a set flag.
        do_reset();
        wr_en_i = 1; wr_addr_i = 5;
        tick();
        wr_en_i = 0; rd_en_i = 2'b01; rd_addr_i = {5'd0, 5'd5}; ctl_set_i = 3'b001;
        tick();
        ctl_set_i = 0;
        #1;
        chk("pre rst dh", {31'd0, dh0}, 1);
        chk("pre rst ch", {31'd0, ch0}, 1);
        chk("pre rst cnt", {16'd0, cnt0}, 1);
        #1;
        rst_i = 1;
        #1;
        chk("async rst dh", {31'd0, dh0}, 0);
        chk("async rst ch", {31'd0, ch0}, 0);
        chk("async rst cnt", {16'd0, cnt0}, 0);
        rst_i = 0;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 4-stage data/control hazard detector.
- Generalised in register-address width, read-port count, tracked pipeline depth and number of control-hazard channels.
- Adds an optional forwarding mode: per read port, a bypass stage select is produced, and a stall is raised only when the youngest matching producer's result is not yet available.
- Sits beside the decode stage. Consumes decoded write info and read requests; drives the stall/bubble logic and the datapath bypass muxes.

Parameters:
- ADDR_W, 5, register address width.
- NUM_RD, 2, number of decode-stage read ports.
- DEPTH, 4, tracked stages after decode; stage 1 = ID/EX, stage DEPTH = register write. Must be >= 2.
- NUM_CTL, 3, control-hazard channels; bit 0 = call, bit 1 = ret, bit 2 = branch.
- FWD_EN, 0, 1 = forwarding mode; 0 = every match stalls.
- ALU_READY, 2, first stage at which a non-load result can be forwarded.
- LOAD_READY, 3, first stage at which a load result can be forwarded.
- ZERO_HARD, 0, 1 = address 0 is hardwired; it never creates or matches a hazard.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- freeze, input, 1, global pipeline hold; scoreboard does not shift.
- flush, input, 1, kill the decode-stage instruction; a bubble enters stage 1.
- wr_en, input, 1, decode instruction writes a register.
- wr_addr, input, ADDR_W, destination register of the decode instruction.
- wr_is_load, input, 1, destination is written by a memory load.
- rd_en, input, NUM_RD, per-port read enable.
- rd_addr, input, NUM_RD*ADDR_W, packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- ctl_set, input, NUM_CTL, set the control-hazard flag per channel.
- ctl_clr, input, NUM_CTL, clear the control-hazard flag per channel.
- data_hazard, output, 1, stall decode this cycle.
- control_hazard, output, 1, OR of all control flags.
- fwd_sel, output, NUM_RD*SEL_W, per-port bypass stage; SEL_W = clog2(DEPTH+1); 0 = register file.
- stall_cnt, output, 16, saturating count of cycles with data_hazard or control_hazard asserted.

Behaviour:
- Scoreboard: DEPTH entries, each {valid, addr, is_load}.
- Reset: all entries invalid, control flags 0, stall_cnt 0. With no valid entries and no flags, data_hazard = 0, control_hazard = 0, fwd_sel = 0.
- Shift, on each clk edge with freeze = 0:
  - entry[k+1] <= entry[k]; entry[DEPTH] is discarded.
  - entry[1] <= {wr_en & ~data_hazard & ~flush & ~(ZERO_HARD & wr_addr == 0), wr_addr, wr_is_load}.
- freeze = 1: all entries hold. freeze has priority over flush and hazard bubbling; flush is ignored while frozen.
- Match, per port i: entry k matches when rd_en[i], entry valid, and addr == rd_addr[i]. If ZERO_HARD and rd_addr[i] == 0, the port never matches.
- Youngest match: the lowest matching k. Only the youngest match counts; older matches are shadowed.
- FWD_EN = 0: port hazard = any match. fwd_sel = 0.
- FWD_EN = 1, youngest match at stage k:
  - ready when k >= (is_load ? LOAD_READY : ALU_READY).
  - ready: fwd_sel[i] = k, no port hazard.
  - not ready: fwd_sel[i] = 0, port hazard asserted.
  - no match: fwd_sel[i] = 0.
- Output timing:
  - data_hazard = OR of port hazards; combinational from current entries and inputs, no added latency.
  - fwd_sel is combinational, same cycle.
- Control flags, per channel, on the clk edge:
  - ctl_clr = 1: flag <= 0. Clear wins over a simultaneous set.
  - else ctl_set = 1: flag <= 1.
  - else: hold.
  - Flags update regardless of freeze.
  - control_hazard does not gate data_hazard, and does not bubble the scoreboard. The decode/stall logic combines the two.
- stall_cnt: increments every clock with data_hazard | control_hazard; saturates at 0xFFFF; cleared only by rst.
- Reset mid-operation: all state clears asynchronously; outputs drop to 0 within the same cycle, except the combinational terms still driven by the inputs.

Decomposition:
- Shared package hazard_pkg holds:
  - scoreboard entry struct {valid, addr, is_load};
  - control channel index constants CTL_CALL = 0, CTL_RET = 1, CTL_BRANCH = 2;
  - SEL_W computation function.
- One sub-module, hazard_port_match: a single read port's youngest-match priority encoder with ready check. Instantiated NUM_RD times via generate.

Test Plan:
- Defaults, FWD_EN = 0: write r5 at decode, next cycle read r5 on port 0.
  - Required: data_hazard = 1 for 4 consecutive cycles (bubbles inserted), then 0.
  - Required: stall_cnt = 4.
- FWD_EN = 1, non-load: ALU writes r7, read r7 one cycle later.
  - Required: hazard 1 cycle, then fwd_sel[0] = 2, hazard 0.
- FWD_EN = 1, load: load writes r7, read r7 next cycle.
  - Required: hazard 2 cycles, then fwd_sel = 3.
- FWD_EN = 1, shadowing: non-load writes r3 at stage 3 and a load writes r3 at stage 1.
  - Required: port stalls; fwd_sel = 0; the stage-3 entry is not selected.
- ZERO_HARD = 1: write r0, then read r0.
  - Required: no hazard, fwd_sel = 0.
- Control flags: ctl_set = 3'b100 → control_hazard = 1 next cycle. Simultaneous ctl_set[2] = 1 and ctl_clr[2] = 1 → flag 0.
- freeze: freeze = 1 for 3 cycles with stage-1 entry r9 → entries unchanged, hazard persists.
- Async reset: rst asserted mid-cycle with a pending hazard → all outputs clear immediately.
